// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Selection is either explicit (sel) or round-robin starting after the last granted channel.
module stream_mux_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_chan,
   output logic               out_valid,
   input  logic               out_ready
);

   logic             load_en_s;
   logic             gnt_vld_s;
   logic [SEL_W-1:0] gnt_idx_s;
   logic [WIDTH-1:0] gnt_data_s;
   logic             xfer_s;
   logic [N-1:0]     in_ready_s;
   int               rr_idx_s;

   logic [SEL_W-1:0] ptr_r;
   logic [WIDTH-1:0] out_data_r;
   logic [SEL_W-1:0] out_chan_r;
   logic             out_valid_r;

   assign load_en_s = !out_valid_r || out_ready;

   // Grant selection: explicit index or first valid channel after ptr_r
   always_comb begin
      gnt_vld_s  = 1'b0;
      gnt_idx_s  = {SEL_W{1'b0}};
      gnt_data_s = {WIDTH{1'b0}};
      rr_idx_s   = 0;
      if (mode == 1'b0) begin
         // sel values at or beyond N match no channel, so they never grant
         for (int k = 0; k < N; k++) begin
            gnt_idx_s  = ((sel == SEL_W'(k)) && in_valid[k]) ? SEL_W'(k) : gnt_idx_s;
            gnt_data_s = ((sel == SEL_W'(k)) && in_valid[k]) ? in_data[k*WIDTH +: WIDTH] : gnt_data_s;
            gnt_vld_s  = gnt_vld_s || ((sel == SEL_W'(k)) && in_valid[k]);
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            rr_idx_s   = (int'(ptr_r) + 1 + k) % N;
            gnt_idx_s  = (!gnt_vld_s && in_valid[rr_idx_s]) ? SEL_W'(rr_idx_s) : gnt_idx_s;
            gnt_data_s = (!gnt_vld_s && in_valid[rr_idx_s]) ? in_data[rr_idx_s*WIDTH +: WIDTH] : gnt_data_s;
            gnt_vld_s  = gnt_vld_s || in_valid[rr_idx_s];
         end
      end
   end

   assign xfer_s = !rst && gnt_vld_s && load_en_s;

   // One-hot ready toward the granted channel only
   always_comb begin
      in_ready_s = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         in_ready_s[k] = xfer_s && (gnt_idx_s == SEL_W'(k));
      end
   end

   assign in_ready = in_ready_s;

   // Output register and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {WIDTH{1'b0}};
         out_chan_r  <= {SEL_W{1'b0}};
         ptr_r       <= SEL_W'(N - 1);
      end else begin
         if (load_en_s) begin
            if (gnt_vld_s) begin
               out_valid_r <= 1'b1;
               out_data_r  <= gnt_data_s;
               out_chan_r  <= gnt_idx_s;
            end else begin
               out_valid_r <= 1'b0;
            end
         end
         if (xfer_s && mode) begin
            ptr_r <= gnt_idx_s;
         end
      end
   end

   assign out_data  = out_data_r;
   assign out_chan  = out_chan_r;
   assign out_valid = out_valid_r;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshake and a registered output stage.
- Two selection modes: explicit select (direct successor of the 4:1 combinational mux) and round-robin arbitration.
- Reports which channel produced each output word.
- Sits between several producer streams and one shared consumer, e.g. a shared UART TX or display path.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high.
- out_data  output  WIDTH  registered output word.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority.
  - in_ready is all-zero while rst=1.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new word when it is empty or is being drained in the same cycle. This gives full throughput of one word per cycle.
- Grant (combinational, with g = granted index):
  - mode=0: g=sel when sel<N and in_valid[sel]=1; otherwise no grant. sel>=N never grants.
  - mode=1: g is the first k with in_valid[k]=1, scanning ptr+1, ptr+2, ... modulo N. No grant if in_valid=0.
- Handshake:
  - in_ready[g] = load_en when a grant exists. All other in_ready bits are 0.
  - in_ready never depends on in_valid of non-granted channels.
- Transfer on clk edge when in_valid[g] && in_ready[g]:
  - out_data <= in_data[g].
  - out_chan <= g.
  - out_valid <= 1.
- If load_en=1 and there is no grant, out_valid <= 0 (the word drains, nothing replaces it).
- Stall: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable and all in_ready are 0.
- Latency: an input accepted at edge t appears on out_data after edge t, one cycle.
- Pointer:
  - ptr <= g only on a transfer while mode=1.
  - ptr is unchanged in mode=0 or when there is no transfer.
  - Wrap: g=N-1 makes channel 0 next in priority.
- Mode/sel changes:
  - Take effect on the grant computed in the current cycle.
  - Never alter a word already in the output register.
- Fairness: with all N channels continuously valid and out_ready=1, mode=1 grants 0,1,...,N-1,0,... with no channel skipped or repeated.
- Reset mid-stream: a held word is discarded and no in_ready is asserted during the reset cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=0000 throughout.
- Explicit select: mode=0, sel=2, N=4, WIDTH=8, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=1111, out_ready=1 -> in_ready=0100; next cycle out_data=8'h33, out_chan=2, out_valid=1 every cycle.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 from reset -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid continuously 1.
- Round-robin skip: mode=1, in_valid=1010 from reset -> out_chan sequence 1,3,1,3. in_ready[0] and in_ready[2] stay 0.
- Backpressure: a word from channel 1 (8'h22) is held and out_ready=0 for 3 cycles while in_data changes -> out_data stays 8'h22, out_chan stays 1, in_ready=0000. When out_ready=1, the next grant loads in that same cycle.
- Invalid sel and mid-stream reset: mode=0 with sel=3, in_valid=0111 -> no grant, out_valid falls to 0 after drain. Then rst=1 while out_valid=1 -> next edge out_valid=0, and in mode=1 the first grant goes to channel 0.
